sobel_window_gen: RTL and testbench
===================================

// Module: sobel_window_gen
// PURPOSE
//  Streaming 3x3 window generator that feeds the sobel core. Accepts one 8-bit pixel per
//  handshake in raster order, buffers the two previous image lines, and presents the eight
//  neighbours p0..p8 (p4 omitted; sobel does not use it) zero-extended to 9 bits.
//  Only full interior windows are emitted; the one-pixel image border produces no output.
// PARAMETERS
//  IMG_W  64  pixels per line, >= 3
//  IMG_H  64  lines per frame, >= 3
//  PIX_W  8   input pixel width; outputs are PIX_W+1 bits
// PORTS
//  clk        in   1      single clock, all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      pixel present on in_data
//  in_data    in   PIX_W  pixel, raster order (row-major, col 0 first)
//  in_ready   out  1      block can accept a pixel this cycle
//  win_valid  out  1      p0..p8 hold a valid window
//  win_ready  in   1      downstream accepts window this cycle
//  p0,p1,p2   out  PIX_W+1  top row, left..right, MSB = 0
//  p3,p5      out  PIX_W+1  middle row, left/right, MSB = 0
//  p6,p7,p8   out  PIX_W+1  bottom row, left..right, MSB = 0
//  win_row    out  clog2(IMG_H)  row of window centre
//  win_col    out  clog2(IMG_W)  column of window centre
//  frame_done out  1      one-cycle pulse after last pixel of a frame is accepted
// BEHAVIOUR
//  - Reset values: in_ready=1 after first post-reset cycle; win_valid=0, p*=0, win_row=0,
//    win_col=0, frame_done=0; row/col counters=0; 3x3 shift registers=0.
//  - Reset mid-frame restarts at (0,0); line-buffer RAMs are not cleared (rows 0,1 rewrite
//    them before any read is used). A window pending at reset is dropped.
//  - in_ready = !win_valid | win_ready (single output register, no extra skid).
//  - Accept = in_valid & in_ready. Only on accept: write pixel to line buffer at col, shift
//    3x3 registers left by one column (new column = {lb1[col], lb0[col], in_data}), advance
//    col; at col=IMG_W-1 wrap col to 0 and advance row; at (IMG_H-1,IMG_W-1) wrap to (0,0)
//    and pulse frame_done next cycle.
//  - Line buffers: lb0 = previous line, lb1 = line before it; on accept lb1[col]<=lb0[col],
//    lb0[col]<=in_data (read-before-write at same address).
//  - Window emission: accept of pixel (r,c) with r>=2 and c>=2 loads p0..p8 and sets
//    win_valid on the next edge; centre = (r-1,c-1). Latency 1 cycle from accept.
//  - Layout: p0=(r-2,c-2) p1=(r-2,c-1) p2=(r-2,c) p3=(r-1,c-2) p5=(r-1,c)
//    p6=(r,c-2) p7=(r,c-1) p8=(r,c). Windows per frame = (IMG_W-2)*(IMG_H-2).
//  - Accept with no window (border) while win_ready=1: win_valid clears.
//  - win_valid & !win_ready: outputs held stable, in_ready=0, counters frozen.
//  - Window consumed and new window loaded same cycle: win_valid stays 1, no bubble.
//  - in_valid gaps: no state change, held window remains until consumed.
//  - Columns 0,1 of each row may hold stale previous-row data in shift regs; never emitted.
// TESTING
//  1 IMG_W=IMG_H=4, pixel=16*row+col, win_ready=1 -> first window after (2,2): p0=00 p1=01
//    p2=02 p3=10 p5=12 p6=20 p7=21 p8=22, centre (1,1); exactly 4 windows, last centre (2,2).
//  2 Same stream, win_ready=0 from first win_valid for 5 cycles -> in_ready=0, p* and
//    win_row/col unchanged 5 cycles; after release, all 4 windows delivered, none lost/duped.
//  3 Two back-to-back frames -> frame_done pulses once per frame, cycle after (3,3) accepted;
//    second frame windows identical to first.
//  4 Random in_valid gaps (50%) with random win_ready -> window sequence matches
//    software 3x3 model of a 16x8 image; count = 14*6 = 84.
//  5 rst asserted after row 2 col 1 of frame, then fresh frame -> no window before new
//    (2,2); first window matches new frame data only, win_valid=0 during reset.
//  6 Max pixel 0xFF everywhere -> all p* = 9'h0FF (MSB zero), sobel out = 0.

Source files
------------

// File: rtl/sobel_window_gen.sv
// 3x3 neighbourhood generator for the sobel core: two line buffers plus a 2-column shift register.
// Window registered 1 cycle after the accept of its bottom-right pixel; a held window stalls input.
module sobel_window_gen #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [PIX_W-1:0]         in_data,
    output logic                     in_ready,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic [PIX_W:0]           p0,
    output logic [PIX_W:0]           p1,
    output logic [PIX_W:0]           p2,
    output logic [PIX_W:0]           p3,
    output logic [PIX_W:0]           p5,
    output logic [PIX_W:0]           p6,
    output logic [PIX_W:0]           p7,
    output logic [PIX_W:0]           p8,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col,
    output logic                     frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    logic [PIX_W-1:0] lb0_mem [IMG_W];
    logic [PIX_W-1:0] lb1_mem [IMG_W];
    logic [PIX_W-1:0] lb0_rd, lb1_rd;

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    // suffix 1 = column c-1, suffix 2 = column c-2 relative to the incoming pixel
    logic [PIX_W-1:0] top1_q, top1_d, top2_q, top2_d;
    logic [PIX_W-1:0] mid1_q, mid1_d, mid2_q, mid2_d;
    logic [PIX_W-1:0] bot1_q, bot1_d, bot2_q, bot2_d;
    logic [PIX_W-1:0] p0_q, p0_d, p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
    logic [PIX_W-1:0] p5_q, p5_d, p6_q, p6_d, p7_q, p7_d, p8_q, p8_d;
    logic          win_valid_q, win_valid_d;
    logic [RW-1:0] win_row_q, win_row_d;
    logic [CW-1:0] win_col_q, win_col_d;
    logic          frame_done_q, frame_done_d;
    logic          accept;

    assign in_ready = !win_valid_q || win_ready;
    assign accept   = in_valid && in_ready;
    assign lb0_rd   = lb0_mem[col_q];
    assign lb1_rd   = lb1_mem[col_q];

    // Line buffers are never reset; rows 0 and 1 of every frame overwrite them before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_mem[col_q] <= lb0_rd;
            lb0_mem[col_q] <= in_data;
        end
    end

    always_comb begin
        row_d        = row_q;
        col_d        = col_q;
        top1_d       = top1_q;
        top2_d       = top2_q;
        mid1_d       = mid1_q;
        mid2_d       = mid2_q;
        bot1_d       = bot1_q;
        bot2_d       = bot2_q;
        p0_d         = p0_q;
        p1_d         = p1_q;
        p2_d         = p2_q;
        p3_d         = p3_q;
        p5_d         = p5_q;
        p6_d         = p6_q;
        p7_d         = p7_q;
        p8_d         = p8_q;
        win_valid_d  = win_valid_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        frame_done_d = 1'b0;

        if (win_ready) begin
            win_valid_d = 1'b0;
        end

        if (accept) begin
            top2_d = top1_q;
            top1_d = lb1_rd;
            mid2_d = mid1_q;
            mid1_d = lb0_rd;
            bot2_d = bot1_q;
            bot1_d = in_data;

            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + ROW_ONE;
                end
            end else begin
                col_d = col_q + COL_ONE;
            end

            // Border pixels only prime the buffers; interior ones complete a window.
            if (row_q >= ROW_TWO && col_q >= COL_TWO) begin
                win_valid_d = 1'b1;
                p0_d        = top2_q;
                p1_d        = top1_q;
                p2_d        = lb1_rd;
                p3_d        = mid2_q;
                p5_d        = lb0_rd;
                p6_d        = bot2_q;
                p7_d        = bot1_q;
                p8_d        = in_data;
                win_row_d   = row_q - ROW_ONE;
                win_col_d   = col_q - COL_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q        <= '0;
            col_q        <= '0;
            top1_q       <= '0;
            top2_q       <= '0;
            mid1_q       <= '0;
            mid2_q       <= '0;
            bot1_q       <= '0;
            bot2_q       <= '0;
            p0_q         <= '0;
            p1_q         <= '0;
            p2_q         <= '0;
            p3_q         <= '0;
            p5_q         <= '0;
            p6_q         <= '0;
            p7_q         <= '0;
            p8_q         <= '0;
            win_valid_q  <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            top1_q       <= top1_d;
            top2_q       <= top2_d;
            mid1_q       <= mid1_d;
            mid2_q       <= mid2_d;
            bot1_q       <= bot1_d;
            bot2_q       <= bot2_d;
            p0_q         <= p0_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            p3_q         <= p3_d;
            p5_q         <= p5_d;
            p6_q         <= p6_d;
            p7_q         <= p7_d;
            p8_q         <= p8_d;
            win_valid_q  <= win_valid_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_valid  = win_valid_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign frame_done = frame_done_q;
    assign p0 = {1'b0, p0_q};
    assign p1 = {1'b0, p1_q};
    assign p2 = {1'b0, p2_q};
    assign p3 = {1'b0, p3_q};
    assign p5 = {1'b0, p5_q};
    assign p6 = {1'b0, p6_q};
    assign p7 = {1'b0, p7_q};
    assign p8 = {1'b0, p8_q};
endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench: a 4x4 instance for the directed cases and a 16x8 instance for the random-gap case.
module tb_sobel_window_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, win_ready;
    logic [7:0] in_data;

    logic       a_in_ready, a_win_valid, a_frame_done;
    logic [8:0] a_p0, a_p1, a_p2, a_p3, a_p5, a_p6, a_p7, a_p8;
    logic [1:0] a_win_row, a_win_col;
    logic       b_in_ready, b_win_valid, b_frame_done;
    logic [8:0] b_p0, b_p1, b_p2, b_p3, b_p5, b_p6, b_p7, b_p8;
    logic [2:0] b_win_row;
    logic [3:0] b_win_col;

    sobel_window_gen #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
        .win_valid(a_win_valid), .win_ready(win_ready),
        .p0(a_p0), .p1(a_p1), .p2(a_p2), .p3(a_p3), .p5(a_p5), .p6(a_p6), .p7(a_p7), .p8(a_p8),
        .win_row(a_win_row), .win_col(a_win_col), .frame_done(a_frame_done)
    );

    sobel_window_gen #(.IMG_W(16), .IMG_H(8), .PIX_W(8)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
        .win_valid(b_win_valid), .win_ready(win_ready),
        .p0(b_p0), .p1(b_p1), .p2(b_p2), .p3(b_p3), .p5(b_p5), .p6(b_p6), .p7(b_p7), .p8(b_p8),
        .win_row(b_win_row), .win_col(b_win_col), .frame_done(b_frame_done)
    );

    int n_run = 0;
    int n_fail = 0;
    int cyc = 0;
    int first_wv_cyc, acc_first_cyc, msb_err, stall_hits;
    logic [79:0] got[$];
    int fd_cyc[$];
    int acc_last_cyc[$];
    logic [7:0] img [8][16];

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic wv(input bit sel);
        return sel ? b_win_valid : a_win_valid;
    endfunction

    function automatic logic rdy(input bit sel);
        return sel ? b_in_ready : a_in_ready;
    endfunction

    function automatic logic fdone(input bit sel);
        return sel ? b_frame_done : a_frame_done;
    endfunction

    // {centre row, centre col, p0 p1 p2 p3 p5 p6 p7 p8} with the pixel MSBs stripped
    function automatic logic [79:0] cur_win(input bit sel);
        if (sel)
            return {5'd0, b_win_row, 4'd0, b_win_col, b_p0[7:0], b_p1[7:0], b_p2[7:0], b_p3[7:0],
                    b_p5[7:0], b_p6[7:0], b_p7[7:0], b_p8[7:0]};
        return {6'd0, a_win_row, 6'd0, a_win_col, a_p0[7:0], a_p1[7:0], a_p2[7:0], a_p3[7:0],
                a_p5[7:0], a_p6[7:0], a_p7[7:0], a_p8[7:0]};
    endfunction

    function automatic logic msb(input bit sel);
        if (sel)
            return b_p0[8] | b_p1[8] | b_p2[8] | b_p3[8] | b_p5[8] | b_p6[8] | b_p7[8] | b_p8[8];
        return a_p0[8] | a_p1[8] | a_p2[8] | a_p3[8] | a_p5[8] | a_p6[8] | a_p7[8] | a_p8[8];
    endfunction

    function automatic logic [79:0] exp_win(input int r, input int c);
        return {8'(r), 8'(c), img[r-1][c-1], img[r-1][c], img[r-1][c+1], img[r][c-1], img[r][c+1],
                img[r+1][c-1], img[r+1][c], img[r+1][c+1]};
    endfunction

    task automatic clear();
        got.delete();
        fd_cyc.delete();
        acc_last_cyc.delete();
        first_wv_cyc  = -1;
        acc_first_cyc = -100;
        msb_err       = 0;
        stall_hits    = 0;
    endtask

    task automatic sample(input bit sel, input bit wr);
        if (wv(sel) && wr) got.push_back(cur_win(sel));
        if (wv(sel) && first_wv_cyc < 0) first_wv_cyc = cyc;
        if (fdone(sel)) fd_cyc.push_back(cyc);
        if (wv(sel) && msb(sel)) msb_err++;
    endtask

    task automatic run(input bit sel, input int npix, input bit stall, input bit rnd);
        int W = sel ? 16 : 4;
        int H = sel ? 8 : 4;
        int idx = 0;
        int budget = 0;
        int stall_left = 0;
        bit stall_started = 1'b0;
        logic [79:0] snap = '0;
        bit v, wr, acc;
        while (idx < npix && budget < 4000) begin
            @(negedge clk);
            cyc++;
            budget++;
            if (stall && !stall_started && wv(sel)) begin
                stall_started = 1'b1;
                stall_left    = 5;
                snap          = cur_win(sel);
            end
            wr = (stall_left == 0) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            v  = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_valid  = v;
            in_data   = img[(idx / W) % H][idx % W];
            win_ready = wr;
            #1;
            sample(sel, wr);
            acc = v && rdy(sel);
            if (stall_left > 0) begin
                check("stall_in_ready", rdy(sel), 1'b0);
                check("stall_hold", cur_win(sel), snap);
                stall_hits++;
                stall_left--;
            end
            if (acc) begin
                if (idx % (W * H) == 2 * W + 2) acc_first_cyc = cyc;
                if (idx % (W * H) == W * H - 1) acc_last_cyc.push_back(cyc);
                idx++;
            end
        end
        check("run_budget", idx, npix);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cyc++;
            in_valid  = 1'b0;
            win_ready = 1'b1;
            #1;
            sample(sel, 1'b1);
        end
    endtask

    task automatic check_frames(input bit sel, input int nframes);
        int W = sel ? 16 : 4;
        int H = sel ? 8 : 4;
        int k = 0;
        check("win_count", got.size(), nframes * (W - 2) * (H - 2));
        for (int f = 0; f < nframes; f++)
            for (int r = 1; r <= H - 2; r++)
                for (int c = 1; c <= W - 2; c++) begin
                    if (k < got.size())
                        check($sformatf("win_f%0d_r%0d_c%0d", f, r, c), got[k], exp_win(r, c));
                    k++;
                end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            rst       = 1'b1;
            in_valid  = 1'b1;
            in_data   = 8'hAA;
            win_ready = 1'b1;
            #1;
            if (i > 0) begin
                check("rst_win_valid_a", a_win_valid, 1'b0);
                check("rst_win_valid_b", b_win_valid, 1'b0);
                check("rst_frame_done_a", a_frame_done, 1'b0);
            end
        end
        @(negedge clk);
        cyc++;
        rst       = 1'b0;
        in_valid  = 1'b0;
        win_ready = 1'b0;
        #1;
        check("rst_in_ready", a_in_ready, 1'b1);
        check("rst_win_a", cur_win(0), 80'd0);
        check("rst_win_b", cur_win(1), 80'd0);
        check("rst_msb", msb(0), 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        win_ready = 1'b0;
        clear();
        do_reset(3);

        // 4x4 ramp, free-flowing output
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++) img[r][c] = 8'(16 * r + c);
        clear();
        run(0, 16, 0, 0);
        check_frames(0, 1);
        if (got.size() > 0) check("first_win", got[0], {8'd1, 8'd1, 64'h00_01_02_10_12_20_21_22});
        if (got.size() > 3) check("last_centre", got[3][79:64], 16'h0202);
        check("win_latency", first_wv_cyc, acc_first_cyc + 1);

        // output stalled for 5 cycles on the first window
        clear();
        run(0, 16, 1, 0);
        check("stall_cycles", stall_hits, 5);
        check_frames(0, 1);

        // two back-to-back frames
        clear();
        run(0, 32, 0, 0);
        check_frames(0, 2);
        check("frame_done_count", fd_cyc.size(), 2);
        if (fd_cyc.size() == 2 && acc_last_cyc.size() == 2) begin
            check("frame_done_t0", fd_cyc[0], acc_last_cyc[0] + 1);
            check("frame_done_t1", fd_cyc[1], acc_last_cyc[1] + 1);
        end

        // reset after (2,1), then a fresh frame with different data
        clear();
        run(0, 10, 0, 0);
        check("no_win_partial", got.size(), 0);
        do_reset(3);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++) img[r][c] = 8'(16 * r + c + 128);
        clear();
        run(0, 16, 0, 0);
        check_frames(0, 1);
        check("post_rst_latency", first_wv_cyc, acc_first_cyc + 1);

        // saturated pixels keep the zero MSB
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++) img[r][c] = 8'hFF;
        clear();
        run(0, 16, 0, 0);
        check_frames(0, 1);
        check("msb_zero", msb_err, 0);

        // 16x8 random image with random input gaps and output backpressure
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++) img[r][c] = 8'($urandom_range(0, 255));
        do_reset(2);
        clear();
        run(1, 128, 0, 1);
        check_frames(1, 1);
        check("rand_frame_done", fd_cyc.size(), 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
